// File: rtl/burst_xfer_unit.sv
// Block-transfer engine between a cache line buffer and a bus master port (INCR burst or single beats).
// Define WRAP_CRITICAL_FIRST_EN to issue burst-mode transfers as critical-word-first WRAP bursts.
module burst_xfer_unit #(
   parameter int DATA_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic                      i_start_read,
   input  logic                      i_start_write,
   input  logic                      i_burst_mode,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic [BLOCK_WIDTH-1:0]    i_block,
   output logic [BLOCK_WIDTH-1:0]    o_block,
   output logic                      o_done,
   output logic                      o_error,
   output logic                      o_req_read,
   output logic                      o_req_write,
   output logic [ADDR_WIDTH-1:0]     o_addr,
   output logic [7:0]                o_len,
   output logic [2:0]                o_size,
   output logic [1:0]                o_burst,
   output logic [DATA_WIDTH/8-1:0]   o_strb,
   output logic [DATA_WIDTH-1:0]     o_wdata,
   input  logic                      i_beat,
   input  logic [DATA_WIDTH-1:0]     i_rdata,
   input  logic                      i_resp_err,
   input  logic                      i_txn_done
);

   localparam int BEATS   = BLOCK_WIDTH / DATA_WIDTH;
   localparam int IW      = $clog2(BEATS);
   localparam int KW      = IW + 1;
   localparam int BOFF    = $clog2(DATA_WIDTH / 8);
   localparam int BLK_OFF = $clog2(BLOCK_WIDTH / 8);

`ifdef WRAP_CRITICAL_FIRST_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_e;

   state_e                 state_q;
   logic                   op_wr_q, burst_q, err_q;
   logic                   req_rd_q, req_wr_q, done_q, error_q;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [IW-1:0]          k0_q;
   logic [KW-1:0]          k_q, k_d;
   logic [BLOCK_WIDTH-1:0] line_q;
   logic                   beat_ok, err_d;
   logic [IW-1:0]          slice_idx;

   // k counts beats already transferred and saturates at BEATS
   assign beat_ok   = (state_q == REQ) && i_beat;
   assign k_d       = (beat_ok && (k_q != KW'(BEATS))) ? k_q + 1'b1 : k_q;
   assign err_d     = err_q | ((state_q == REQ) && i_resp_err && (i_beat || i_txn_done));
   assign slice_idx = k0_q + k_q[IW-1:0];

   assign o_block     = line_q;
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_req_read  = req_rd_q;
   assign o_req_write = req_wr_q;

   always_comb begin
      o_addr  = '0;
      o_len   = '0;
      o_size  = '0;
      o_burst = '0;
      o_strb  = '0;
      o_wdata = '0;
      if (state_q == REQ) begin
         o_size  = 3'(BOFF);
         o_strb  = '1;
         o_wdata = line_q[slice_idx*DATA_WIDTH +: DATA_WIDTH];
         if (burst_q) begin
            o_addr  = base_q | (ADDR_WIDTH'(k0_q) << BOFF);
            o_len   = 8'(BEATS - 1);
            o_burst = WRAP_EN ? 2'b10 : 2'b01;
         end else begin
            o_addr  = base_q + (ADDR_WIDTH'(k_q) << BOFF);
            o_burst = 2'b01;
         end
      end
   end

   // NOTE: all state updates use <= so every branch sees the pre-edge values of the _q registers.
   always_ff @(posedge clk) begin
      if (arst) begin
         state_q  <= IDLE;
         op_wr_q  <= 1'b0;
         burst_q  <= 1'b0;
         err_q    <= 1'b0;
         req_rd_q <= 1'b0;
         req_wr_q <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         base_q   <= '0;
         k0_q     <= '0;
         k_q      <= '0;
         // NOTE: the line buffer is visible on o_block, so it is cleared like any other output.
         line_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start_write || i_start_read) begin
                  op_wr_q  <= i_start_write;
                  burst_q  <= i_burst_mode;
                  base_q   <= i_addr & ~ADDR_WIDTH'(BLOCK_WIDTH/8 - 1);
                  k0_q     <= (WRAP_EN && i_burst_mode) ? i_addr[BLK_OFF-1:BOFF] : '0;
                  k_q      <= '0;
                  err_q    <= 1'b0;
                  req_wr_q <= i_start_write;
                  req_rd_q <= !i_start_write;
                  if (i_start_write) line_q <= i_block;
                  state_q  <= REQ;
               end
            end
            REQ: begin
               k_q   <= k_d;
               err_q <= err_d;
               if (beat_ok && !op_wr_q && (k_q != KW'(BEATS)))
                  line_q[slice_idx*DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
               if (i_txn_done) begin
                  req_rd_q <= 1'b0;
                  req_wr_q <= 1'b0;
                  if (burst_q || (k_d == KW'(BEATS))) begin
                     done_q  <= 1'b1;
                     error_q <= err_d | (burst_q && (k_d != KW'(BEATS)));
                     state_q <= DONE;
                  end else begin
                     state_q <= GAP;
                  end
               end
            end
            GAP: begin
               req_rd_q <= !op_wr_q;
               req_wr_q <= op_wr_q;
               state_q  <= REQ;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/burst_xfer_unit.md
Name: burst_xfer_unit

Overview:
- Parametrised block-transfer engine between a cache line (BLOCK_WIDTH bits) and a bus master port (DATA_WIDTH bits per beat).
- Generalises the two existing paths, the AXI4 burst FIFO and the APB word-by-word transfer, into one unit.
- Supports two per-request modes: one INCR burst of BEATS beats, or BEATS independent single-beat transactions with incrementing address.
- Sits between the cache/datapath request interface and the AXI4 master. Adds error capture and an optional critical-word-first wrap burst.

Parameters:
- DATA_WIDTH, 64, beat width in bits; must be 32 or 64.
- BLOCK_WIDTH, 512, cache block width in bits; BEATS = BLOCK_WIDTH/DATA_WIDTH, a power of 2, 2..256.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock.
- arst  in  1  reset, synchronous, active-high.
- i_start_read  in  1  block read request, level, held until o_done.
- i_start_write  in  1  block write request, level, held until o_done.
- i_burst_mode  in  1  1 = single burst; 0 = BEATS single-beat transactions. Sampled at start.
- i_addr  in  ADDR_WIDTH  request address, any byte within the block.
- i_block  in  BLOCK_WIDTH  write block, sampled at start.
- o_block  out  BLOCK_WIDTH  internal line buffer; read result valid from o_done.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky error for the finished transfer, valid with o_done.
- o_req_read  out  1  read request to the master.
- o_req_write  out  1  write request to the master.
- o_addr  out  ADDR_WIDTH  transaction address.
- o_len  out  8  AXI len.
- o_size  out  3  log2(DATA_WIDTH/8).
- o_burst  out  2  AXI burst type.
- o_strb  out  DATA_WIDTH/8  all ones.
- o_wdata  out  DATA_WIDTH  current write beat.
- i_beat  in  1  per-beat handshake: read data valid, or write beat accepted.
- i_rdata  in  DATA_WIDTH  read beat.
- i_resp_err  in  1  error response, qualified by i_beat or i_txn_done.
- i_txn_done  in  1  master transaction complete.

Behaviour:
- Reset: all outputs 0; buffer, counter and error flag cleared; state IDLE. Reset mid-transfer aborts with no o_done, and the next cycle is IDLE.
- States: IDLE, REQ, GAP, DONE.
- Block base = i_addr with low log2(BLOCK_WIDTH/8) bits cleared.

IDLE:
- On i_start_write or i_start_read, latch op, mode and base.
- On write, also latch i_block into the buffer.
- Beat index k = 0. Go to REQ.
- If both starts are high, write wins; the read is served on a later start.

REQ:
- o_req_* is high.
- o_addr:
  - Burst mode: base.
  - Single mode: base + k*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
- o_len: BEATS-1 in burst mode, 0 in single mode.
- o_burst = 2'b01.
- o_wdata = buffer[k*DATA_WIDTH +: DATA_WIDTH].
- On each i_beat:
  - Read: buffer slice k <= i_rdata.
  - Both ops: k increments, saturating at BEATS; i_resp_err ORs into the error flag.
- i_resp_err with i_txn_done also ORs into the error flag.
- On i_txn_done:
  - Burst mode: if the beat count (including an i_beat in the same cycle) is not BEATS, set the error flag. Go to DONE.
  - Single mode: if k reaches BEATS, go to DONE; else go to GAP.
- A beat and i_txn_done in the same cycle are both honoured.

GAP:
- o_req_* low for exactly one cycle, then return to REQ with the next address.

DONE:
- o_done = 1 for one cycle, o_error = flag, then IDLE.
- Starts are ignored in the DONE cycle; the requester drops start on o_done.
- o_block holds its value until the next read beat or write start.

Other rules:
- i_beat outside REQ is ignored.
- Latency:
  - Burst mode: o_done follows i_txn_done by one cycle.
  - Single mode: two cycles per beat of overhead (GAP plus re-request).

Optional Feature:
- Macro: WRAP_CRITICAL_FIRST_EN.
- Defined: burst mode uses o_burst = 2'b10 (WRAP) with o_addr = i_addr aligned to DATA_WIDTH/8. The start index is k0 = beat containing i_addr. Slice index = (k0 + n) mod BEATS for beat n. Completion and error rules are unchanged.
- Not defined: the INCR-from-base behaviour above. Single mode is unaffected either way.

Test Plan:
- Burst read, defaults, addr 0x8000_0040: 8 beats 0x11..0x88 -> o_addr 0x8000_0040, o_len 7, o_size 3; o_block slice k = beat k; o_done one cycle after i_txn_done; o_error 0.
- Single-mode write, DATA_WIDTH=32, addr 0x1000_0004: 16 transactions, o_addr 0x1000_0000..0x1000_003C step 4; o_len 0; o_wdata = word k; one idle GAP cycle between requests.
- i_start_read and i_start_write high together -> write performed first; read served only after o_done and a fresh start.
- Burst read with i_txn_done after 5 beats -> o_done with o_error 1. Next transfer with clean responses -> o_error 0.
- arst asserted mid-burst after 3 beats -> next cycle all outputs 0 and IDLE; no o_done; a subsequent full burst completes correctly.
- WRAP_CRITICAL_FIRST_EN defined, read addr 0x8000_0028 -> o_addr 0x8000_0028, o_burst 2'b10; beats fill slices 5,6,7,0,1,2,3,4.
